pla_onehot_capture: RTL and testbench

//  Registered consumer stage directly downstream of the 4-output PLA.

---
 rtl/pla_onehot_capture.sv | 131 +++++++++++++
 tb/tb_pla_onehot_capture.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pla_onehot_capture.sv
// Registered consumer for the 4-line one-hot PLA decode: validates the word,
// recovers {A,B}, counts hits/errors and locks after a streak of malformed words.
module pla_onehot_capture #(
    parameter int CNT_W     = 8,
    parameter int ERR_LIMIT = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         f_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         out_code,
    output logic               out_err,
    input  logic               clr,
    output logic [4*CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0]   err_cnt,
    output logic               sticky_err,
    output logic               locked
);

    localparam int CW = $clog2(ERR_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(ERR_LIMIT);

    typedef enum logic {RUN, LOCKED} state_e;

    state_e                      state_q, state_d;
    logic                        out_valid_q, out_valid_d;
    logic [1:0]                  out_code_q, out_code_d;
    logic                        out_err_q, out_err_d;
    logic [3:0][CNT_W-1:0]       hit_q, hit_d;
    logic [CNT_W-1:0]            err_cnt_q, err_cnt_d;
    logic                        sticky_q, sticky_d;
    logic [CW-1:0]               consec_q, consec_d;

    logic       accept;
    logic       good;
    logic [1:0] code;
    logic [1:0] lane;

    assign in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        // NOTE: every variable gets its default first so no path can infer a latch.
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_code_d  = out_code_q;
        out_err_d   = out_err_q;
        hit_d       = hit_q;
        err_cnt_d   = err_cnt_q;
        sticky_d    = sticky_q;
        consec_d    = consec_q;
        good        = 1'b0;
        code        = 2'b00;
        lane        = 2'd0;

        // Decode only on accept so an undriven f_in while idle never propagates.
        if (accept) begin
            unique case (f_in)
                4'b0001: begin good = 1'b1; code = 2'b11; lane = 2'd0; end
                4'b0010: begin good = 1'b1; code = 2'b10; lane = 2'd1; end
                4'b0100: begin good = 1'b1; code = 2'b01; lane = 2'd2; end
                4'b1000: begin good = 1'b1; code = 2'b00; lane = 2'd3; end
                default: begin good = 1'b0; code = 2'b00; lane = 2'd0; end
            endcase
        end

        if (accept) begin
            out_valid_d = 1'b1;
            out_code_d  = code;
            out_err_d   = !good;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (good) begin
                if (hit_q[lane] != '1) hit_d[lane] = hit_q[lane] + CNT_W'(1);
                consec_d = '0;
            end else begin
                if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
                sticky_d = 1'b1;
                if (consec_q < LIMIT) consec_d = consec_q + CW'(1);
                if (consec_d == LIMIT) state_d = LOCKED;
            end
        end

        // Clear overrides any same-cycle count update but leaves the output word alone.
        if (clr) begin
            hit_d     = '0;
            err_cnt_d = '0;
            sticky_d  = 1'b0;
            consec_d  = '0;
            state_d   = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            out_valid_q <= 1'b0;
            out_code_q  <= 2'b00;
            out_err_q   <= 1'b0;
            hit_q       <= '0;
            err_cnt_q   <= '0;
            sticky_q    <= 1'b0;
            consec_q    <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its peers.
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_code_q  <= out_code_d;
            out_err_q   <= out_err_d;
            hit_q       <= hit_d;
            err_cnt_q   <= err_cnt_d;
            sticky_q    <= sticky_d;
            consec_q    <= consec_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_code   = out_code_q;
    assign out_err    = out_err_q;
    assign hit_cnt    = hit_q;
    assign err_cnt    = err_cnt_q;
    assign sticky_err = sticky_q;
    assign locked     = (state_q == LOCKED);

endmodule

// File: tb/tb_pla_onehot_capture.sv
// Scoreboard bench for pla_onehot_capture: directed words push expected {code,err},
// a negedge monitor pops on every output transfer; a CNT_W=2 twin covers saturation.
module tb_pla_onehot_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  f_in;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_code;
    logic        out_err;
    logic        clr;
    logic [31:0] hit_cnt;
    logic [7:0]  err_cnt;
    logic        sticky_err;
    logic        locked;

    logic        in_ready2, out_valid2, out_err2, sticky_err2, locked2;
    logic [1:0]  out_code2;
    logic [7:0]  hit_cnt2;
    logic [1:0]  err_cnt2;

    int total = 0;
    int bad   = 0;
    int last_wait;
    logic [2:0] sb_q[$];

    always #5 clk = ~clk;

    pla_onehot_capture #(.CNT_W(8), .ERR_LIMIT(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .f_in(f_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code), .out_err(out_err),
        .clr(clr), .hit_cnt(hit_cnt), .err_cnt(err_cnt), .sticky_err(sticky_err), .locked(locked)
    );

    pla_onehot_capture #(.CNT_W(2), .ERR_LIMIT(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .f_in(f_in),
        .out_valid(out_valid2), .out_ready(out_ready), .out_code(out_code2), .out_err(out_err2),
        .clr(clr), .hit_cnt(hit_cnt2), .err_cnt(err_cnt2), .sticky_err(sticky_err2), .locked(locked2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one word, wait (bounded) for in_ready, record expectation, cross the accept edge.
    task automatic send(input logic [3:0] f, input logic [1:0] c, input logic e);
        in_valid  = 1'b1;
        f_in      = f;
        last_wait = 0;
        @(negedge clk);
        while (!in_ready && last_wait < 50) begin
            @(negedge clk);
            last_wait++;
        end
        if (!in_ready) begin
            check("send_timeout", 32'd0, 32'd1);
        end else begin
            sb_q.push_back({c, e});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        f_in     = 4'bxxxx;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_word", 32'd1, 32'd0);
            end else begin
                logic [2:0] e;
                e = sb_q.pop_front();
                check("sb_code", 32'(out_code), 32'(e[2:1]));
                check("sb_err", 32'(out_err), 32'(e[0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        f_in      = 4'bxxxx;
        out_ready = 1'b1;
        clr       = 1'b0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_code", 32'(out_code), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_hit_cnt", hit_cnt, 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_sticky", 32'(sticky_err), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // T1 decode
        send(4'b0001, 2'b11, 1'b0);
        send(4'b0010, 2'b10, 1'b0);
        send(4'b0100, 2'b01, 1'b0);
        send(4'b1000, 2'b00, 1'b0);
        step();
        check("t1_hit_cnt", hit_cnt, 32'h01010101);
        check("t1_err_cnt", 32'(err_cnt), 32'd0);

        // T2 backpressure then bypass
        out_ready = 1'b0;
        send(4'b0100, 2'b01, 1'b0);
        in_valid = 1'b1;
        f_in     = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_hold_in_ready", 32'(in_ready), 32'd0);
            check("t2_hold_valid", 32'(out_valid), 32'd1);
            check("t2_hold_code", 32'(out_code), 32'b01);
        end
        step();
        out_ready = 1'b1;
        send(4'b1000, 2'b00, 1'b0);
        check("t2_bypass_wait", 32'(last_wait), 32'd0);
        send(4'b0001, 2'b11, 1'b0);
        check("t2_b2b_wait", 32'(last_wait), 32'd0);
        @(negedge clk);
        check("t2_no_bubble", 32'(out_valid), 32'd1);
        check("t2_hit_cnt", hit_cnt, 32'h02020102);
        step();

        // T3 malformed words and lock
        send(4'b0000, 2'b00, 1'b1);
        send(4'b0011, 2'b00, 1'b1);
        check("t3_not_locked_yet", 32'(locked), 32'd0);
        send(4'b1111, 2'b00, 1'b1);
        @(negedge clk);
        check("t3_err_cnt", 32'(err_cnt), 32'd3);
        check("t3_sticky", 32'(sticky_err), 32'd1);
        check("t3_locked", 32'(locked), 32'd1);
        check("t3_in_ready", 32'(in_ready), 32'd0);
        step();
        in_valid = 1'b1;
        f_in     = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_locked_in_ready", 32'(in_ready), 32'd0);
        end
        step();
        in_valid = 1'b0;
        pulse_clr();
        @(negedge clk);
        check("t3_clr_locked", 32'(locked), 32'd0);
        check("t3_clr_err_cnt", 32'(err_cnt), 32'd0);
        check("t3_clr_sticky", 32'(sticky_err), 32'd0);
        check("t3_clr_hit_cnt", hit_cnt, 32'd0);
        check("t3_clr_in_ready", 32'(in_ready), 32'd1);
        step();

        // T4 error streak broken by a good word
        send(4'b0000, 2'b00, 1'b1);
        send(4'b0110, 2'b00, 1'b1);
        send(4'b0010, 2'b10, 1'b0);
        send(4'b1100, 2'b00, 1'b1);
        send(4'b0111, 2'b00, 1'b1);
        @(negedge clk);
        check("t4_locked", 32'(locked), 32'd0);
        check("t4_err_cnt", 32'(err_cnt), 32'd4);
        check("t4_hit_cnt", hit_cnt, 32'h00000100);
        check("t4_in_ready", 32'(in_ready), 32'd1);
        step();
        pulse_clr();

        // T5 saturation on the CNT_W=2 twin, then clear beats increment
        for (int i = 0; i < 5; i++) send(4'b0001, 2'b11, 1'b0);
        @(negedge clk);
        check("t5_sat_cnt_f1", 32'(hit_cnt2), 32'h00000003);
        check("t5_wide_cnt_f1", hit_cnt, 32'h00000005);
        step();
        clr = 1'b1;
        send(4'b0010, 2'b10, 1'b0);
        clr = 1'b0;
        check("t5_clr_ready", 32'(last_wait), 32'd0);
        @(negedge clk);
        check("t5_clr_hit_cnt", hit_cnt, 32'd0);
        check("t5_clr_hit_cnt2", 32'(hit_cnt2), 32'd0);
        check("t5_clr_word_valid", 32'(out_valid), 32'd1);
        step();

        // T6 async reset with a pending word
        out_ready = 1'b0;
        send(4'b0100, 2'b01, 1'b0);
        @(negedge clk);
        check("t6_pending", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_hit_cnt", hit_cnt, 32'd0);
        check("t6_rst_code", 32'(out_code), 32'd0);
        sb_q.delete();
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(4'b1000, 2'b00, 1'b0);
        @(negedge clk);
        check("t6_post_hit_cnt", hit_cnt, 32'h01000000);
        repeat (3) step();
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
